// File: rtl/seq_array_multiplier.sv
// seq_array_multiplier
// Iterative shift-add multiplier that handles one multiplier bit per clock.
// Operands arrive over a valid/ready handshake and the product leaves over a second one.
// Two's-complement operation is selected per transaction. In that mode the
// multiplier's sign bit carries weight -2^(WIDTH-1), so the last row is subtracted.
module seq_array_multiplier #(
   parameter int WIDTH     = 4,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_m,
   input  logic [WIDTH-1:0]     in_q,
   input  logic                 in_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_p,
   output logic                 busy
);

   // One guard bit above the product keeps the signed corner cases exact.
   localparam int AW = 2 * WIDTH + 1;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [WIDTH-1:0]     m_reg, m_next;
   logic [WIDTH-1:0]     q_reg, q_next;
   logic                 sgn_reg, sgn_next;
   logic [AW-1:0]        acc_reg, acc_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [2*WIDTH-1:0]   out_p_reg, out_p_next;

   // Multiplicand widened to accumulator width: sign-extended in signed mode,
   // zero-extended otherwise.
   logic [AW-1:0] m_ext;

   genvar gi;
   generate
      for (gi = 0; gi < AW; gi++) begin : g_m_ext
         if (gi < WIDTH) begin : g_low
            assign m_ext[gi] = m_reg[gi];
         end else begin : g_high
            assign m_ext[gi] = sgn_reg & m_reg[WIDTH-1];
         end
      end
   endgenerate

   // Current partial-product row, already shifted to weight 2^cnt.
   logic [AW-1:0] row;
   logic          last_bit;
   logic          sub_row;
   logic [AW-1:0] acc_sum;

   // Single adder row: add the shifted partial product, or subtract it for the sign bit.
   always_comb begin
      row      = '0;
      last_bit = (cnt_reg == LAST_CNT);
      sub_row  = sgn_reg & last_bit;
      if (q_reg[cnt_reg]) begin
         row = m_ext << cnt_reg;
      end
      if (sub_row) begin
         acc_sum = acc_reg - row;
      end else begin
         acc_sum = acc_reg + row;
      end
   end

   // State and datapath registers; reset discards any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         m_reg     <= '0;
         q_reg     <= '0;
         sgn_reg   <= 1'b0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         out_p_reg <= '0;
      end else begin
         state_reg <= state_next;
         m_reg     <= m_next;
         q_reg     <= q_next;
         sgn_reg   <= sgn_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         out_p_reg <= out_p_next;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_next = state_reg;
      m_next     = m_reg;
      q_next     = q_reg;
      sgn_next   = sgn_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      out_p_next = out_p_reg;

      case (state_reg)
         ST_IDLE: begin
            if (in_valid) begin
               m_next     = in_m;
               q_next     = in_q;
               sgn_next   = in_signed & SIGNED_EN;
               acc_next   = '0;
               cnt_next   = '0;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_next = acc_sum;
            if (last_bit) begin
               // The product register changes only here, so it stays put through DONE and IDLE.
               out_p_next = acc_sum[2*WIDTH-1:0];
               state_next = ST_DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign busy      = (state_reg != ST_IDLE);
   assign out_p     = out_p_reg;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Testbench for seq_array_multiplier: directed WIDTH=4 cases plus random WIDTH=8
// runs against a plain-arithmetic reference model.
module tb_seq_array_multiplier;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=4, SIGNED_EN=1 instance
   logic       in_valid4 = 1'b0, in_signed4 = 1'b0, out_ready4 = 1'b0;
   logic [3:0] in_m4 = '0, in_q4 = '0;
   logic       in_ready4, out_valid4, busy4;
   logic [7:0] out_p4;

   // WIDTH=8 instances (SIGNED_EN=1 and 0) sharing the same stimulus
   logic        in_valid8 = 1'b0, in_signed8 = 1'b0, out_ready8 = 1'b0;
   logic [7:0]  in_m8 = '0, in_q8 = '0;
   logic        in_ready8s, out_valid8s, busy8s;
   logic        in_ready8u, out_valid8u, busy8u;
   logic [15:0] out_p8s, out_p8u;

   seq_array_multiplier #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_m(in_m4), .in_q(in_q4), .in_signed(in_signed4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_p(out_p4), .busy(busy4));

   seq_array_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8s (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8s),
      .in_m(in_m8), .in_q(in_q8), .in_signed(in_signed8),
      .out_valid(out_valid8s), .out_ready(out_ready8), .out_p(out_p8s), .busy(busy8s));

   seq_array_multiplier #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8u (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8u),
      .in_m(in_m8), .in_q(in_q8), .in_signed(in_signed8),
      .out_valid(out_valid8u), .out_ready(out_ready8), .out_p(out_p8u), .busy(busy8u));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: interpret operands as integers, multiply, keep 2*w bits.
   function automatic longint ref_prod(input int w, input longint m, input longint q, input bit s);
      longint a, b;
      a = m;
      b = q;
      if (s) begin
         if (a >= (64'sd1 <<< (w - 1))) a = a - (64'sd1 <<< w);
         if (b >= (64'sd1 <<< (w - 1))) b = b - (64'sd1 <<< w);
      end
      return (a * b) & ((64'sd1 <<< (2 * w)) - 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one W=4 transaction, wait (bounded) for completion; product not yet consumed.
   task automatic run4(input logic [3:0] m, input logic [3:0] q, input logic s,
                       output logic [7:0] p, output int lat);
      check("w4_in_ready_before_accept", in_ready4, 1'b1);
      in_m4 = m; in_q4 = q; in_signed4 = s; in_valid4 = 1'b1; out_ready4 = 1'b0;
      tick();
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 20) begin
         tick();
         lat++;
      end
      p = out_p4;
   endtask

   task automatic consume4();
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
   endtask

   logic [7:0] p4, p_hold;
   int         lat;

   initial begin
      // ---------------- reset state ----------------
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready", in_ready4, 1'b1);
      check("rst_out_valid", out_valid4, 1'b0);
      check("rst_busy", busy4, 1'b0);
      check("rst_out_p", out_p4, 8'h00);

      // ---------------- basic products ----------------
      run4(4'd15, 4'd15, 1'b0, p4, lat);
      check("u15x15_p", p4, 8'hE1);
      check("u15x15_latency", lat, 4);
      check("done_busy", busy4, 1'b1);
      check("done_in_ready", in_ready4, 1'b0);
      consume4();
      check("after_hs_out_valid", out_valid4, 1'b0);
      check("after_hs_out_p_kept", out_p4, 8'hE1);

      run4(4'h8, 4'h8, 1'b1, p4, lat);  check("s_m8xm8", p4, 8'h40);  consume4();
      run4(4'h8, 4'h7, 1'b1, p4, lat);  check("s_m8x7", p4, 8'hC8);   consume4();
      run4(4'h8, 4'h8, 1'b0, p4, lat);  check("u8x8", p4, 8'h40);     consume4();
      run4(4'h7, 4'hF, 1'b1, p4, lat);  check("s_7xm1", p4, 8'hF9);   consume4();

      // ---------------- backpressure ----------------
      run4(4'd13, 4'd11, 1'b0, p4, lat);
      p_hold = p4;
      check("bp_p", p4, 8'd143);
      in_m4 = 4'd1; in_q4 = 4'd1; in_valid4 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_out_valid", out_valid4, 1'b1);
         check("bp_out_p_stable", out_p4, p_hold);
         check("bp_in_ready", in_ready4, 1'b0);
      end
      in_valid4 = 1'b0;
      consume4();
      check("bp_release_in_ready", in_ready4, 1'b1);
      check("bp_release_busy", busy4, 1'b0);
      check("bp_release_out_p", out_p4, p_hold);

      // ---------------- reset mid-RUN (cnt=2) ----------------
      in_m4 = 4'd9; in_q4 = 4'd9; in_signed4 = 1'b0; in_valid4 = 1'b1;
      tick();                 // accept edge -> RUN cnt=0
      in_valid4 = 1'b0;
      tick(); tick();         // now in RUN with cnt=2
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_in_ready", in_ready4, 1'b1);
      check("midrst_out_valid", out_valid4, 1'b0);
      check("midrst_out_p", out_p4, 8'h00);
      check("midrst_busy", busy4, 1'b0);
      run4(4'd3, 4'd5, 1'b0, p4, lat);
      check("after_rst_3x5", p4, 8'd15);
      check("after_rst_latency", lat, 4);
      consume4();

      // ---------------- back-to-back issue ----------------
      begin
         logic [7:0] exp_q[$];
         int cyc, last_acc, accepted, done;
         bit acc_now;
         cyc = 0; last_acc = 0; accepted = 0; done = 0;
         in_m4 = 4'($urandom); in_q4 = 4'($urandom); in_signed4 = 1'($urandom);
         in_valid4 = 1'b1; out_ready4 = 1'b1;
         while (done < 5 && cyc < 200) begin
            if (out_valid4) begin
               if (exp_q.size() > 0) check("b2b_p", out_p4, exp_q.pop_front());
               else check("b2b_unexpected_out", out_valid4, 1'b0);
               done++;
            end
            acc_now = in_ready4 && in_valid4;
            if (acc_now) exp_q.push_back(8'(ref_prod(4, longint'(in_m4), longint'(in_q4), in_signed4)));
            tick();
            cyc++;
            if (acc_now) begin
               if (accepted > 0) check("b2b_interval", cyc - last_acc, 6);
               last_acc = cyc;
               accepted++;
               if (accepted < 5) begin
                  in_m4 = 4'($urandom); in_q4 = 4'($urandom); in_signed4 = 1'($urandom);
               end else begin
                  in_valid4 = 1'b0;
               end
            end
         end
         check("b2b_completed", done, 5);
         out_ready4 = 1'b0;
      end

      // ---------------- WIDTH=8 random, both SIGNED_EN settings ----------------
      for (int t = 0; t < 1000; t++) begin
         logic [15:0] exp_s, exp_u;
         int wait_cyc;
         if (!(in_ready8s && in_ready8u)) check("w8_in_ready", {in_ready8s, in_ready8u}, 2'b11);
         in_m8 = 8'($urandom); in_q8 = 8'($urandom); in_signed8 = 1'($urandom);
         if (t < 4) begin
            in_m8 = (t[0]) ? 8'h80 : 8'hFF;
            in_q8 = (t[1]) ? 8'h80 : 8'hFF;
            in_signed8 = 1'b1;
         end
         exp_s = 16'(ref_prod(8, longint'(in_m8), longint'(in_q8), in_signed8));
         exp_u = 16'(ref_prod(8, longint'(in_m8), longint'(in_q8), 1'b0));
         in_valid8 = 1'b1;
         tick();
         in_valid8 = 1'b0;
         in_signed8 = ~in_signed8;   // must not influence the running product
         wait_cyc = 0;
         while (!(out_valid8s && out_valid8u) && wait_cyc < 30) begin
            tick();
            wait_cyc++;
         end
         if (wait_cyc != 8) check("w8_latency", wait_cyc, 8);
         check("w8_signed_en_p", out_p8s, exp_s);
         check("w8_unsigned_only_p", out_p8u, exp_u);
         out_ready8 = 1'b1;
         tick();
         out_ready8 = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
